// File: rtl/tdc_pulsegen.sv
// CSR-programmable test-pulse train generator feeding a TDC channel input.
// Define TDC_PULSEGEN_CONTINUOUS_EN to let COUNT=0 start an endless train.
module tdc_pulsegen #(
  parameter logic [3:0]  csr_addr  = 4'h2,
  parameter int unsigned cnt_width = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq,
  output logic        pulse_o
);

`ifdef TDC_PULSEGEN_CONTINUOUS_EN
  localparam bit ContEn = 1'b1;
`else
  localparam bit ContEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic [cnt_width-1:0] rem_q, rem_d;
  logic [cnt_width-1:0] period_q, period_d;
  logic [cnt_width-1:0] width_q, width_d;
  logic [cnt_width-1:0] count_q, count_d;
  logic [cnt_width-1:0] per_sh_q, per_sh_d;
  logic [cnt_width-1:0] wid_sh_q, wid_sh_d;
  logic                 cont_q, cont_d;
  logic                 irq_en_q, irq_en_d;
  logic                 irq_pend_q, irq_pend_d;
  logic                 err_q, err_d;
  logic                 pulse_q, pulse_d;
  logic                 irq_q, irq_d;
  logic [31:0]          csr_do_q, csr_do_d;

  logic       sel, wr;
  logic [2:0] idx;
  logic       start_req, stop_req, start_valid, busy;
  logic [31:0] rdata;
  logic       unused_ok;

  assign sel       = (csr_a[13:10] == csr_addr);
  assign idx       = csr_a[2:0];
  assign wr        = csr_we & sel;
  assign busy      = (state_q != S_IDLE);
  assign unused_ok = ^{csr_a[9:3], csr_di};

  // Register file, FSM and read mux
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    period_d   = period_q;
    width_d    = width_q;
    count_d    = count_q;
    per_sh_d   = per_sh_q;
    wid_sh_d   = wid_sh_q;
    cont_d     = cont_q;
    irq_en_d   = irq_en_q;
    irq_pend_d = irq_pend_q;
    err_d      = err_q;
    start_req  = wr && (idx == 3'd0) && csr_di[0];
    stop_req   = wr && (idx == 3'd0) && csr_di[1];
    rdata      = '0;

    if (wr) begin
      case (idx)
        3'd0: irq_en_d = csr_di[2];
        3'd1: begin
          if (csr_di[1]) irq_pend_d = 1'b0;
          if (csr_di[2]) err_d      = 1'b0;
        end
        3'd2: period_d = csr_di[cnt_width-1:0];
        3'd3: width_d  = csr_di[cnt_width-1:0];
        3'd4: count_d  = csr_di[cnt_width-1:0];
        default: ;
      endcase
    end

    start_valid = (width_d != '0) && (period_d > width_d) &&
                  ((count_d != '0) || ContEn);

    case (state_q)
      S_IDLE: begin
        if (start_req && !stop_req) begin
          if (start_valid) begin
            per_sh_d = period_d;
            wid_sh_d = width_d;
            cont_d   = ContEn && (count_d == '0);
            rem_d    = (count_d == '0) ? '0 : count_d - cnt_width'(1);
            cnt_d    = width_d - cnt_width'(1);
            state_d  = S_HIGH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_HIGH: begin
        if (stop_req) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          // Last pulse ends the train directly; no trailing low phase
          if ((rem_q == '0) && !cont_q) begin
            state_d    = S_IDLE;
            irq_pend_d = 1'b1;
          end else begin
            state_d = S_LOW;
            cnt_d   = per_sh_q - wid_sh_q - cnt_width'(1);
          end
        end else begin
          cnt_d = cnt_q - cnt_width'(1);
        end
      end
      S_LOW: begin
        if (stop_req) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_HIGH;
          cnt_d   = wid_sh_q - cnt_width'(1);
          if (!cont_q) rem_d = rem_q - cnt_width'(1);
        end else begin
          cnt_d = cnt_q - cnt_width'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    pulse_d = (state_d == S_HIGH);
    irq_d   = irq_pend_d & irq_en_d;

    case (idx)
      3'd0:    rdata = 32'({irq_en_q, 2'b00});
      3'd1:    rdata = 32'({err_q, irq_pend_q, busy});
      3'd2:    rdata = 32'(period_q);
      3'd3:    rdata = 32'(width_q);
      3'd4:    rdata = 32'(count_q);
      3'd5:    rdata = 32'(rem_q);
      default: rdata = '0;
    endcase
    csr_do_d = sel ? rdata : '0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      period_q   <= '0;
      width_q    <= '0;
      count_q    <= '0;
      per_sh_q   <= '0;
      wid_sh_q   <= '0;
      cont_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      err_q      <= 1'b0;
      pulse_q    <= 1'b0;
      irq_q      <= 1'b0;
      csr_do_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      period_q   <= period_d;
      width_q    <= width_d;
      count_q    <= count_d;
      per_sh_q   <= per_sh_d;
      wid_sh_q   <= wid_sh_d;
      cont_q     <= cont_d;
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      err_q      <= err_d;
      pulse_q    <= pulse_d;
      irq_q      <= irq_d;
      csr_do_q   <= csr_do_d;
    end
  end

  assign pulse_o = pulse_q;
  assign irq     = irq_q;
  assign csr_do  = csr_do_q;

endmodule

// File: tb/tb_tdc_pulsegen.sv
// Directed bench for tdc_pulsegen: scoreboard queues for CSR reads and per-cycle pulse/irq samples.
module tb_tdc_pulsegen;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        irq;
  logic        pulse_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic p;
    logic i;
  } smp_t;

  logic [31:0] rd_q[$];
  smp_t        pq[$];

  tdc_pulsegen dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .csr_a   (csr_a),
    .csr_we  (csr_we),
    .csr_di  (csr_di),
    .csr_do  (csr_do),
    .irq     (irq),
    .pulse_o (pulse_o)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] ra(input logic [2:0] idx);
    return {4'h2, 7'd0, idx};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [31:0] d);
    csr_a  = a;
    csr_di = d;
    csr_we = 1'b1;
    @(negedge sys_clk);
    csr_we = 1'b0;
    csr_di = '0;
  endtask

  task automatic csr_read(input string tag, input logic [13:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    csr_a  = a;
    csr_we = 1'b0;
    @(negedge sys_clk);
    check(tag, csr_do, rd_q.pop_front());
  endtask

  // Expected pulse_o/irq from the first high cycle up to and including the completion cycle
  task automatic push_train(input int period, input int width, input int count, input logic irq_end);
    for (int n = 0; n < count; n++) begin
      for (int c = 0; c < ((n == count - 1) ? width : period); c++) begin
        pq.push_back('{p: (c < width), i: 1'b0});
      end
    end
    pq.push_back('{p: 1'b0, i: irq_end});
  endtask

  // Consume the sample queue one cycle at a time, optionally injecting one CSR write
  task automatic run_train(input int inj_at, input logic [13:0] ia, input logic [31:0] id);
    smp_t e;
    int   i;
    i = 0;
    while (pq.size() > 0) begin
      e = pq.pop_front();
      check($sformatf("pulse t%0d", i + 1), 32'(pulse_o), 32'(e.p));
      check($sformatf("irq t%0d", i + 1), 32'(irq), 32'(e.i));
      if (i == inj_at) begin
        csr_a  = ia;
        csr_di = id;
        csr_we = 1'b1;
      end else if (i == inj_at + 1) begin
        csr_we = 1'b0;
        csr_di = '0;
      end
      i++;
      @(negedge sys_clk);
    end
    csr_we = 1'b0;
    csr_di = '0;
  endtask

  initial begin
    int last_rise;
    int rises;
    logic prev;

    sys_rst = 1'b1;
    csr_we  = 1'b0;
    csr_a   = '0;
    csr_di  = '0;
    repeat (3) @(negedge sys_clk);
    check("reset pulse_o", 32'(pulse_o), 32'd0);
    check("reset irq", 32'(irq), 32'd0);
    check("reset csr_do", csr_do, 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    csr_read("reset STATUS", ra(1), 32'h0);

    // Basic two-pulse train with completion interrupt
    csr_write(ra(2), 32'd10);
    csr_write(ra(3), 32'd3);
    csr_write(ra(4), 32'd2);
    csr_write(ra(0), 32'h4);
    csr_write(ra(0), 32'h5);
    push_train(10, 3, 2, 1'b1);
    run_train(-10, '0, '0);
    csr_read("t1 STATUS", ra(1), 32'h2);
    csr_read("t1 REMAINING", ra(5), 32'h0);
    csr_read("t1 CTRL", ra(0), 32'h4);
    csr_read("t1 PERIOD", ra(2), 32'd10);
    csr_read("other page", {4'h3, 7'd0, 3'd2}, 32'h0);
    csr_read("index 6", ra(6), 32'h0);
    csr_write(ra(1), 32'h2);
    check("irq after W1C", 32'(irq), 32'd0);
    csr_read("STATUS after W1C", ra(1), 32'h0);

    // Invalid start: PERIOD == WIDTH
    csr_write(ra(2), 32'd3);
    csr_write(ra(0), 32'h5);
    for (int k = 0; k < 4; k++) begin
      check("invalid start pulse", 32'(pulse_o), 32'd0);
      @(negedge sys_clk);
    end
    csr_read("err STATUS", ra(1), 32'h4);
    csr_write(ra(1), 32'h4);
    csr_read("err cleared", ra(1), 32'h0);

    // Stop during the second pulse; start while busy is ignored
    csr_write(ra(2), 32'd100);
    csr_write(ra(3), 32'd50);
    csr_write(ra(4), 32'd5);
    csr_write(ra(0), 32'h5);
    csr_write(ra(0), 32'h5);
    repeat (108) @(negedge sys_clk);
    check("2nd pulse high", 32'(pulse_o), 32'd1);
    csr_write(ra(0), 32'h6);
    check("stop pulse_o", 32'(pulse_o), 32'd0);
    check("stop irq", 32'(irq), 32'd0);
    csr_read("stop STATUS", ra(1), 32'h0);
    csr_read("stop REMAINING", ra(5), 32'd3);
    check("stop pulse held low", 32'(pulse_o), 32'd0);

    // PERIOD rewrite mid-train only affects the next start
    csr_write(ra(2), 32'd10);
    csr_write(ra(3), 32'd3);
    csr_write(ra(4), 32'd3);
    csr_write(ra(0), 32'h5);
    push_train(10, 3, 3, 1'b1);
    run_train(4, ra(2), 32'd20);
    csr_write(ra(1), 32'h2);
    csr_write(ra(4), 32'd2);
    csr_write(ra(0), 32'h5);
    push_train(20, 3, 2, 1'b1);
    run_train(-10, '0, '0);
    csr_write(ra(1), 32'h2);

    // Completion coincident with W1C of irq_pending: set wins
    csr_write(ra(2), 32'd10);
    csr_write(ra(4), 32'd1);
    csr_write(ra(0), 32'h5);
    push_train(10, 3, 1, 1'b1);
    run_train(2, ra(1), 32'h2);
    csr_read("set wins STATUS", ra(1), 32'h2);

    // Asynchronous reset in the middle of a high phase
    csr_write(ra(3), 32'd5);
    csr_write(ra(4), 32'd3);
    csr_write(ra(0), 32'h5);
    @(negedge sys_clk);
    check("pre-reset high", 32'(pulse_o), 32'd1);
    #2 sys_rst = 1'b1;
    #1;
    check("async reset pulse_o", 32'(pulse_o), 32'd0);
    check("async reset irq", 32'(irq), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int r = 0; r < 6; r++) begin
      csr_read($sformatf("post-reset reg%0d", r), ra(3'(r)), 32'h0);
    end

    // COUNT=0 start
    csr_write(ra(2), 32'd10);
    csr_write(ra(3), 32'd3);
    csr_write(ra(0), 32'h5);
`ifdef TDC_PULSEGEN_CONTINUOUS_EN
    last_rise = -1;
    rises     = 0;
    prev      = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      if (pulse_o && !prev) begin
        if (last_rise >= 0) check("continuous spacing", 32'(k - last_rise), 32'd10);
        last_rise = k;
        rises++;
      end
      prev = pulse_o;
      @(negedge sys_clk);
    end
    check("continuous edges", 32'(rises >= 110), 32'd1);
    check("continuous irq", 32'(irq), 32'd0);
    csr_read("continuous REMAINING", ra(5), 32'h0);
    csr_write(ra(0), 32'h6);
    check("continuous stop pulse", 32'(pulse_o), 32'd0);
    csr_read("continuous STATUS", ra(1), 32'h0);
`else
    last_rise = 0;
    rises     = 0;
    prev      = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("count0 pulse", 32'(pulse_o), 32'd0);
      @(negedge sys_clk);
    end
    csr_read("count0 STATUS", ra(1), 32'h4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_pulsegen.md
Name: tdc_pulsegen

Overview:
- CSR-bus test-pulse generator that sits directly upstream of the TDC core and feeds one of its `signal_i` channel inputs.
- Produces a programmable train of pulses with a set period, high width and pulse count, so software can exercise and characterise the TDC without external stimulus.
- Occupies one CSR page and raises an interrupt when a train completes.

Parameters:
- csr_addr, 4'h2, CSR page; the block responds when csr_a[13:10] == csr_addr.
- cnt_width, 16, width of the PERIOD, WIDTH, COUNT and REMAINING registers.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset, asynchronous, active-high; all state clears immediately on assertion.
- csr_a  in  14  CSR address; [13:10] page select, [2:0] register index.
- csr_we  in  1  CSR write strobe.
- csr_di  in  32  CSR write data.
- csr_do  out  32  CSR read data, registered; 0 when not selected (bus is OR-combined).
- irq  out  1  level interrupt = irq_pending & irq_en.
- pulse_o  out  1  registered pulse output, to the TDC signal input.

Behaviour:
- Register map, indexed by csr_a[2:0]:
  - 0 CTRL: bit0 start (W, self-clearing), bit1 stop (W, self-clearing), bit2 irq_en (R/W).
  - 1 STATUS: bit0 busy (RO), bit1 irq_pending (W1C), bit2 err (W1C).
  - 2 PERIOD, 3 WIDTH, 4 COUNT: R/W, zero-extended.
  - 5 REMAINING: RO, pulses not yet started.
  - Indexes 6 and 7 read 0; writes to RO fields are ignored.
- Reads: csr_do is valid 1 cycle after the address is applied. When csr_a[13:10] != csr_addr, csr_do is 0 on the next cycle.
- Reset values:
  - pulse_o=0, irq=0, csr_do=0.
  - All registers 0; FSM in IDLE.
- FSM has three states: IDLE, HIGH, LOW. One down-counter (cnt_width bits) tracks the current phase.
- Start is accepted only in IDLE, and only if WIDTH>=1 and PERIOD>WIDTH and COUNT>=1.
  - On acceptance, PERIOD, WIDTH and COUNT are copied into shadow registers. Writes made during a run take effect at the next start.
  - On acceptance, REMAINING is loaded with COUNT-1 and the FSM moves to HIGH on the next edge.
- Start rejection: an invalid start sets err and the FSM stays in IDLE. A start while busy is ignored and does not set err.
- HIGH: pulse_o=1 for exactly WIDTH cycles.
  - If REMAINING=0, go to IDLE.
  - Otherwise go to LOW.
- LOW: pulse_o=0 for PERIOD-WIDTH cycles, then go to HIGH and decrement REMAINING.
- Resulting waveform: rising edges are exactly PERIOD cycles apart. The train ends with the falling edge of the last pulse; there is no trailing low phase.
- Completion: the cycle the FSM enters IDLE from HIGH, irq_pending is set and busy=0.
- Stop: a stop write in HIGH or LOW forces IDLE on the next edge.
  - pulse_o=0 and REMAINING is held.
  - irq_pending is not set.
- Simultaneous events:
  - Start and stop in the same write: stop wins; the FSM stays or goes to IDLE.
  - Completion in the same cycle as a W1C of irq_pending: set wins, and the bit stays 1.
  - Writes to PERIOD, WIDTH or COUNT in the same cycle as start: the new value is used.
- Reset mid-train: pulse_o drops asynchronously. After release the block is in IDLE with all registers cleared.
- Counter arithmetic: unsigned and modulo-free. Reloads use shadow-1, so no wrap-around is possible given the validity checks.

Optional Feature:
- Macro: TDC_PULSEGEN_CONTINUOUS_EN.
- When defined: COUNT=0 is a valid start and runs an endless train.
  - REMAINING reads 0 and does not decrement.
  - Only stop or reset ends the train; irq_pending is never set in this mode.
- When undefined: a start with COUNT=0 is rejected and sets err, as for any invalid start.

Test Plan:
1. Write PERIOD=10, WIDTH=3, COUNT=2, irq_en=1, then start at cycle t0 -> pulse_o high t1–t3, low t4–t10, high t11–t13, low from t14. busy falls and irq=1 at t14; REMAINING reads 0.
2. Start with PERIOD=3, WIDTH=3 -> no pulse, STATUS reads 0x4 (err). W1C of err -> STATUS reads 0.
3. PERIOD=100, WIDTH=50, COUNT=5; write stop during the 2nd pulse -> pulse_o=0 next cycle, busy=0, irq_pending=0, REMAINING=3.
4. Rewrite PERIOD=20 during a running PERIOD=10 train -> the running train keeps the 10-cycle spacing; the next start uses 20.
5. Force completion and a W1C of irq_pending in the same cycle -> irq_pending stays 1. Assert sys_rst mid-HIGH -> pulse_o=0 immediately and all registers read 0.
6. With TDC_PULSEGEN_CONTINUOUS_EN: COUNT=0 start -> pulses continue past 1000 cycles until stop, with no irq. Without the macro, the same start sets err and pulse_o stays 0.
